// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU controller and its arbiter.
package alu_pkg;

    localparam int ALU_W    = 4;
    localparam int ALU_OP_W = 2;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CAPTURE
    } share_state_t;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when
// the grant is actually taken (adv).
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt_onehot,
    output logic       ptr
);

    logic ptr_q;
    logic ptr_d;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        gnt_onehot = 2'b00;
        unique case (req)
            2'b01:   gnt_onehot = 2'b01;
            2'b10:   gnt_onehot = 2'b10;
            2'b11:   gnt_onehot = ptr_q ? 2'b10 : 2'b01;
            default: gnt_onehot = 2'b00;
        endcase

        ptr_d = ptr_q;
        // Winner 0 hands priority to 1 and vice versa.
        if (adv && (gnt_onehot != 2'b00)) begin
            ptr_d = gnt_onehot[0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: arbitrate, hold the
// winner's operands for a settle window, then register the result.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int W             = ALU_W,
    parameter int OP_W          = ALU_OP_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic [W-1:0]    a0,
    input  logic [W-1:0]    b0,
    input  logic [OP_W-1:0] op0,
    input  logic [W-1:0]    a1,
    input  logic [W-1:0]    b1,
    input  logic [OP_W-1:0] op1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            done0,
    output logic            done1,
    output logic [W-1:0]    result,
    output logic            busy,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [W-1:0]    alu_y
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    share_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic [W-1:0]    result_q, result_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;

    logic [1:0]      arb_gnt;
    logic            arb_adv;
    logic            arb_ptr;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({req1, req0}),
        .adv        (arb_adv),
        .gnt_onehot (arb_gnt),
        .ptr        (arb_ptr)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        arb_adv  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Requests are only looked at here, so req changes mid-operation are ignored.
                if (arb_gnt != 2'b00) begin
                    arb_adv  = 1'b1;
                    gnt0_d   = arb_gnt[0];
                    gnt1_d   = arb_gnt[1];
                    owner_d  = arb_gnt[1];
                    alu_a_d  = arb_gnt[1] ? a1  : a0;
                    alu_b_d  = arb_gnt[1] ? b1  : b0;
                    alu_op_d = arb_gnt[1] ? op1 : op0;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                result_d = alu_y;
                done0_d  = ~owner_q;
                done1_d  = owner_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign result = result_q;
    assign busy   = (state_q == DRIVE) || (state_q == CAPTURE);
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: one instance with a 2-cycle settle window,
// one with a 1-cycle window, each driving its own behavioural ALU.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] op0, op1;

    logic       s2_gnt0, s2_gnt1, s2_done0, s2_done1, s2_busy;
    logic [3:0] s2_result, s2_alu_a, s2_alu_b, s2_alu_y;
    logic [1:0] s2_alu_op;

    logic       s1_gnt0, s1_gnt1, s1_done0, s1_done1, s1_busy;
    logic [3:0] s1_result, s1_alu_a, s1_alu_b, s1_alu_y;
    logic [1:0] s1_alu_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] tb_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign s2_alu_y = tb_alu(s2_alu_a, s2_alu_b, s2_alu_op);
    assign s1_alu_y = tb_alu(s1_alu_a, s1_alu_b, s1_alu_op);

    alu_share_ctrl #(.W(4), .OP_W(2), .SETTLE_CYCLES(2)) u_s2 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
        .gnt0(s2_gnt0), .gnt1(s2_gnt1), .done0(s2_done0), .done1(s2_done1),
        .result(s2_result), .busy(s2_busy),
        .alu_a(s2_alu_a), .alu_b(s2_alu_b), .alu_op(s2_alu_op), .alu_y(s2_alu_y)
    );

    alu_share_ctrl #(.W(4), .OP_W(2), .SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
        .gnt0(s1_gnt0), .gnt1(s1_gnt1), .done0(s1_done0), .done1(s1_done1),
        .result(s1_result), .busy(s1_busy),
        .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_op(s1_alu_op), .alu_y(s1_alu_y)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_s2_zero(input string tag);
        check({tag, "_gnt0"},   32'(s2_gnt0),   0);
        check({tag, "_gnt1"},   32'(s2_gnt1),   0);
        check({tag, "_done0"},  32'(s2_done0),  0);
        check({tag, "_done1"},  32'(s2_done1),  0);
        check({tag, "_result"}, 32'(s2_result), 0);
        check({tag, "_busy"},   32'(s2_busy),   0);
        check({tag, "_alu_a"},  32'(s2_alu_a),  0);
        check({tag, "_alu_b"},  32'(s2_alu_b),  0);
        check({tag, "_alu_op"}, 32'(s2_alu_op), 0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; op0 = 2'd0;
        a1 = 4'd0; b1 = 4'd0; op1 = 2'd0;

        // Reset values
        tick(); tick();
        check_s2_zero("rst");
        check("rst_s1_busy", 32'(s1_busy), 0);
        check("rst_s1_gnt0", 32'(s1_gnt0), 0);
        rst = 1'b0;
        tick();

        // Single ADD on requester 0: 3 + 5 = 8, done at T+3
        a0 = 4'd3; b0 = 4'd5; op0 = OP_ADD; req0 = 1'b1;
        tick();
        check("add_gnt0_T",   32'(s2_gnt0),   1);
        check("add_gnt1_T",   32'(s2_gnt1),   0);
        check("add_busy_T",   32'(s2_busy),   1);
        check("add_alu_a",    32'(s2_alu_a),  3);
        check("add_alu_b",    32'(s2_alu_b),  5);
        check("add_alu_op",   32'(s2_alu_op), 0);
        tick();
        check("add_gnt0_T1",  32'(s2_gnt0),   0);
        check("add_busy_T1",  32'(s2_busy),   1);
        tick();
        check("add_done0_T2", 32'(s2_done0),  0);
        check("add_busy_T2",  32'(s2_busy),   1);
        tick();
        check("add_done0_T3", 32'(s2_done0),  1);
        check("add_done1_T3", 32'(s2_done1),  0);
        check("add_result",   32'(s2_result), 8);
        check("add_busy_T3",  32'(s2_busy),   0);
        req0 = 1'b0;
        tick();
        check("add_done0_T4", 32'(s2_done0),  0);
        check("add_gnt0_T4",  32'(s2_gnt0),   0);
        check("add_hold",     32'(s2_result), 8);

        // SUB on requester 1: 2 - 7 wraps to 4'hB
        a1 = 4'd2; b1 = 4'd7; op1 = OP_SUB; req1 = 1'b1;
        tick();
        check("sub_gnt1",     32'(s2_gnt1),   1);
        check("sub_gnt0",     32'(s2_gnt0),   0);
        tick(); tick(); tick();
        check("sub_done1",    32'(s2_done1),  1);
        check("sub_done0",    32'(s2_done0),  0);
        check("sub_result",   32'(s2_result), 32'hB);
        req1 = 1'b0;
        tick();

        // Operand change during DRIVE: latched 6 | 3 = 7, not 1 + 3
        a0 = 4'd6; b0 = 4'd3; op0 = OP_OR; req0 = 1'b1;
        tick();
        check("hold_gnt0",    32'(s2_gnt0),   1);
        a0 = 4'd1; op0 = OP_ADD;
        tick();
        check("hold_alu_a1",  32'(s2_alu_a),  6);
        check("hold_alu_op1", 32'(s2_alu_op), 3);
        tick();
        check("hold_alu_a2",  32'(s2_alu_a),  6);
        check("hold_alu_op2", 32'(s2_alu_op), 3);
        tick();
        check("hold_done0",   32'(s2_done0),  1);
        check("hold_result",  32'(s2_result), 7);
        req0 = 1'b0;
        tick();

        // Pointer now favours requester 1; reset mid-DRIVE must clear it
        a0 = 4'd3; b0 = 4'd5; op0 = OP_ADD;
        a1 = 4'd2; b1 = 4'd7; op1 = OP_SUB;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("pre_rst_gnt1", 32'(s2_gnt1),   1);
        check("pre_rst_gnt0", 32'(s2_gnt0),   0);
        tick();
        check("pre_rst_busy", 32'(s2_busy),   1);
        rst = 1'b1;
        #1;
        check_s2_zero("mid_rst");
        tick();
        check("rst_no_done1", 32'(s2_done1),  0);
        check("rst_no_done0", 32'(s2_done0),  0);
        rst = 1'b0;

        // Both held: gnt0, gnt1, gnt0 ... with 8-cycle period
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("rr_gnt0_%0d", i),  32'(s2_gnt0),  32'(i % 8 == 0));
            check($sformatf("rr_gnt1_%0d", i),  32'(s2_gnt1),  32'(i % 8 == 4));
            check($sformatf("rr_done0_%0d", i), 32'(s2_done0), 32'(i % 8 == 3));
            check($sformatf("rr_done1_%0d", i), 32'(s2_done1), 32'(i % 8 == 7));
            if (i == 3) check("rr_result0", 32'(s2_result), 8);
            if (i == 7) check("rr_result1", 32'(s2_result), 32'hB);
        end

        // One-cycle settle window, continuous req0: grant every 3 cycles
        rst = 1'b1;
        req1 = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("s1_gnt0_%0d", i),  32'(s1_gnt0),  32'(i % 3 == 0));
            check($sformatf("s1_busy_%0d", i),  32'(s1_busy),  32'(i % 3 != 2));
            check($sformatf("s1_done0_%0d", i), 32'(s1_done0), 32'(i % 3 == 2));
            check($sformatf("s1_gnt1_%0d", i),  32'(s1_gnt1),  0);
            if (i % 3 == 2) check($sformatf("s1_result_%0d", i), 32'(s1_result), 8);
        end
        req0 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
